// File: rtl/cache_fill_ctrl.sv
// Miss/write-through controller: dwrite > dmiss > imiss onto one pipelined memory port, 8-word refills + tag write.
// Fill done WORDS_PER_BLOCK+MEM_LATENCY+1 cycles after grant, no stalls; define CACHE_FILL_CWF_EN for critical word first.
module cache_fill_ctrl #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               imiss,
  input  logic [ADDR_W-1:0]                  imiss_addr,
  input  logic                               dmiss,
  input  logic [ADDR_W-1:0]                  dmiss_addr,
  input  logic                               dwrite,
  input  logic [ADDR_W-1:0]                  dwrite_addr,
  input  logic [DATA_W-1:0]                  dwrite_data,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  input  logic                               mem_valid,
  output logic                               fill_we,
  output logic                               fill_sel,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               tag_we,
  output logic [ADDR_W-1:0]                  tag_addr,
  output logic                               ifill_done,
  output logic                               dfill_done,
  output logic                               dwrite_done,
  output logic                               busy
);
  localparam int IdxW   = $clog2(WORDS_PER_BLOCK);
  localparam int CntW   = IdxW + 1;
  localparam int FlushW = $clog2(MEM_LATENCY + 1);
  localparam logic [ADDR_W-1:0] BlockMask = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CntW-1:0]   CntFull   = CntW'(WORDS_PER_BLOCK);
  localparam logic [FlushW-1:0] FlushLast = FlushW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {FLUSH, IDLE, WRITE, FILL, DONE} state_t;

  state_t            state, stateNext;
  logic [CntW-1:0]   icnt, icntNext, rcnt, rcntNext;
  logic [IdxW-1:0]   startIdx, startNext, missStart;
  logic [ADDR_W-1:0] base, baseNext, missAddr;
  logic [FlushW-1:0] flushCnt, flushNext;
  logic              selNext, retire;
  logic              memEnNext, memWrNext, tagWeNext;
  logic              ifillDoneNext, dfillDoneNext, dwriteDoneNext;
  logic [ADDR_W-1:0] memAddrNext, tagAddrNext;
  logic [DATA_W-1:0] memWdataNext;

  // Block base is aligned, so the word offset can simply be OR-ed in.
  function automatic logic [ADDR_W-1:0] wordAddr(input logic [ADDR_W-1:0] blk,
                                                 input logic [IdxW-1:0]   idx);
    return blk | {{(ADDR_W-IdxW-1){1'b0}}, idx, 1'b0};
  endfunction

  // Memory returns in issue order, so the return count alone locates the word.
  assign retire    = (state == FILL) && mem_valid && (rcnt != icnt);
  assign fill_we   = retire;
  assign fill_word = IdxW'(startIdx + rcnt[IdxW-1:0]);
  assign fill_data = retire ? mem_rdata : '0;

  always_comb begin
    stateNext      = state;
    icntNext       = icnt;
    rcntNext       = rcnt;
    startNext      = startIdx;
    baseNext       = base;
    selNext        = fill_sel;
    flushNext      = flushCnt;
    memEnNext      = 1'b0;
    memWrNext      = 1'b0;
    memAddrNext    = '0;
    memWdataNext   = '0;
    tagWeNext      = 1'b0;
    tagAddrNext    = '0;
    ifillDoneNext  = 1'b0;
    dfillDoneNext  = 1'b0;
    dwriteDoneNext = 1'b0;
    missAddr       = dmiss ? dmiss_addr : imiss_addr;
`ifdef CACHE_FILL_CWF_EN
    missStart      = missAddr[IdxW:1];
`else
    missStart      = '0;
`endif

    unique case (state)
      FLUSH: begin
        if (flushCnt == FlushLast) stateNext = IDLE;
        else                       flushNext = flushCnt + 1'b1;
      end
      IDLE: begin
        if (dwrite) begin
          stateNext      = WRITE;
          memEnNext      = 1'b1;
          memWrNext      = 1'b1;
          memAddrNext    = dwrite_addr;
          memWdataNext   = dwrite_data;
          dwriteDoneNext = 1'b1;
        end else if (dmiss || imiss) begin
          stateNext   = FILL;
          baseNext    = missAddr & BlockMask;
          selNext     = dmiss;
          startNext   = missStart;
          icntNext    = CntW'(1);
          rcntNext    = '0;
          memEnNext   = 1'b1;
          memAddrNext = wordAddr(missAddr & BlockMask, missStart);
        end
      end
      WRITE: stateNext = IDLE;
      FILL: begin
        if (icnt != CntFull) begin
          memEnNext   = 1'b1;
          memAddrNext = wordAddr(base, IdxW'(startIdx + icnt[IdxW-1:0]));
          icntNext    = icnt + 1'b1;
        end
        if (retire) begin
          rcntNext = rcnt + 1'b1;
          if (rcnt + 1'b1 == CntFull) begin
            stateNext     = DONE;
            tagWeNext     = 1'b1;
            tagAddrNext   = base;
            ifillDoneNext = ~fill_sel;
            dfillDoneNext = fill_sel;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FLUSH;
      icnt        <= '0;
      rcnt        <= '0;
      startIdx    <= '0;
      base        <= '0;
      fill_sel    <= 1'b0;
      flushCnt    <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      tag_we      <= 1'b0;
      tag_addr    <= '0;
      ifill_done  <= 1'b0;
      dfill_done  <= 1'b0;
      dwrite_done <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= stateNext;
      icnt        <= icntNext;
      rcnt        <= rcntNext;
      startIdx    <= startNext;
      base        <= baseNext;
      fill_sel    <= selNext;
      flushCnt    <= flushNext;
      mem_en      <= memEnNext;
      mem_wr      <= memWrNext;
      mem_addr    <= memAddrNext;
      mem_wdata   <= memWdataNext;
      tag_we      <= tagWeNext;
      tag_addr    <= tagAddrNext;
      ifill_done  <= ifillDoneNext;
      dfill_done  <= dfillDoneNext;
      dwrite_done <= dwriteDoneNext;
      busy        <= (stateNext != IDLE);
    end
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: latency-4 DUT with data=address memory, plus a latency-1 DUT for back-to-back fills.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;
  localparam int W = 8;
  localparam int L = 4;

  bit clk;
  logic rst;
  logic imiss, dmiss, dwrite;
  logic [15:0] imissAddr, dmissAddr, dwriteAddr, dwriteData;
  logic memEn, memWr, memValid;
  logic [15:0] memAddr, memWdata, memRdata;
  logic fillWe, fillSel, tagWe, ifillDone, dfillDone, dwriteDone, busy;
  logic [2:0] fillWord;
  logic [15:0] fillData, tagAddr;

  logic bImiss;
  logic [15:0] bImissAddr;
  logic bMemEn, bMemWr, bMemValid;
  logic [15:0] bMemAddr, bMemWdata, bMemRdata;
  logic bFillWe, bFillSel, bTagWe, bIfillDone, bDfillDone, bDwriteDone, bBusy;
  logic [2:0] bFillWord;
  logic [15:0] bFillData, bTagAddr;

  int cyc = 0;
  int nChk = 0;
  int nErr = 0;
  int bFills = 0;
  logic spur = 1'b0;
  logic [15:0] spurData = 16'h0;
  logic [L-1:0] pv = '0;
  logic [15:0] pa [L];
  logic bPv = 1'b0;
  logic [15:0] bPa = 16'h0;

  typedef struct {
    logic        sel;
    int          word;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } ev_t;
  ev_t expRd[$], expWr[$], expFill[$], expEvt[$], expB[$];

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst),
    .imiss(imiss), .imiss_addr(imissAddr), .dmiss(dmiss), .dmiss_addr(dmissAddr),
    .dwrite(dwrite), .dwrite_addr(dwriteAddr), .dwrite_data(dwriteData),
    .mem_en(memEn), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .mem_valid(memValid),
    .fill_we(fillWe), .fill_sel(fillSel), .fill_word(fillWord), .fill_data(fillData),
    .tag_we(tagWe), .tag_addr(tagAddr),
    .ifill_done(ifillDone), .dfill_done(dfillDone), .dwrite_done(dwriteDone), .busy(busy)
  );

  cache_fill_ctrl #(.MEM_LATENCY(1)) dutB (
    .clk(clk), .rst(rst),
    .imiss(bImiss), .imiss_addr(bImissAddr), .dmiss(1'b0), .dmiss_addr(16'h0),
    .dwrite(1'b0), .dwrite_addr(16'h0), .dwrite_data(16'h0),
    .mem_en(bMemEn), .mem_wr(bMemWr), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
    .mem_rdata(bMemRdata), .mem_valid(bMemValid),
    .fill_we(bFillWe), .fill_sel(bFillSel), .fill_word(bFillWord), .fill_data(bFillData),
    .tag_we(bTagWe), .tag_addr(bTagAddr),
    .ifill_done(bIfillDone), .dfill_done(bDfillDone), .dwrite_done(bDwriteDone), .busy(bBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined memories returning data equal to the read address.
  assign memValid  = pv[L-1] | spur;
  assign memRdata  = spur ? spurData : (pv[L-1] ? pa[L-1] : 16'h0);
  assign bMemValid = bPv;
  assign bMemRdata = bPv ? bPa : 16'h0;
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], memEn & ~memWr};
    pa[0] <= memAddr;
    for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
    bPv   <= bMemEn & ~bMemWr;
    bPa   <= bMemAddr;
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (!ok) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reads issued from grant edge t, returns L later, tag/done at t+W+L.
  task automatic pushFill(input logic sel, input logic [15:0] addr, input int t, input int nRd);
    logic [15:0] base, a;
    int start, w;
    ev_t e;
    base  = addr & 16'hFFF0;
    start = 0;
`ifdef CACHE_FILL_CWF_EN
    start = int'(addr[3:1]);
`endif
    for (int k = 0; k < nRd; k++) begin
      w = (start + k) % W;
      a = base + 16'(2 * w);
      e = '{sel: sel, word: w, addr: a, data: a, cyc: t + k};
      expRd.push_back(e);
      if (nRd == W) begin
        e.cyc = t + L + k;
        expFill.push_back(e);
      end
    end
    if (nRd == W) begin
      e = '{sel: sel, word: 0, addr: base, data: (sel ? 16'h000A : 16'h000C), cyc: t + W + L};
      expEvt.push_back(e);
    end
  endtask

  // Requesters drop on the cycle their done pulse is visible.
  task automatic serve(input int limit);
    int n;
    n = 0;
    while ((imiss || dmiss || dwrite) && n < limit) begin
      @(negedge clk);
      n++;
      if (ifillDone)  imiss  = 1'b0;
      if (dfillDone)  dmiss  = 1'b0;
      if (dwriteDone) dwrite = 1'b0;
    end
    chk(!(imiss || dmiss || dwrite), "serve_timeout", 32'(n), 32'(limit));
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (memEn && memWr) begin
      if (expWr.size() == 0) chk(1'b0, "unexpected_write", {16'h0, memAddr}, 32'h0);
      else begin
        e = expWr.pop_front();
        chk(memAddr == e.addr, "wr_addr", {16'h0, memAddr}, {16'h0, e.addr});
        chk(memWdata == e.data, "wr_data", {16'h0, memWdata}, {16'h0, e.data});
        chk(cyc == e.cyc, "wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (memEn && !memWr) begin
      if (expRd.size() == 0) chk(1'b0, "unexpected_read", {16'h0, memAddr}, 32'h0);
      else begin
        e = expRd.pop_front();
        chk(memAddr == e.addr, "rd_addr", {16'h0, memAddr}, {16'h0, e.addr});
        chk(cyc == e.cyc, "rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (fillWe) begin
      if (expFill.size() == 0) chk(1'b0, "unexpected_fill_we", {16'h0, fillData}, 32'h0);
      else begin
        e = expFill.pop_front();
        chk(fillSel == e.sel, "fill_sel", 32'(fillSel), 32'(e.sel));
        chk(int'(fillWord) == e.word, "fill_word", 32'(fillWord), 32'(e.word));
        chk(fillData == e.data, "fill_data", {16'h0, fillData}, {16'h0, e.data});
        chk(cyc == e.cyc, "fill_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (tagWe || ifillDone || dfillDone || dwriteDone) begin
      if (expEvt.size() == 0)
        chk(1'b0, "unexpected_done", {28'h0, tagWe, ifillDone, dfillDone, dwriteDone}, 32'h0);
      else begin
        e = expEvt.pop_front();
        chk({tagWe, ifillDone, dfillDone, dwriteDone} == e.data[3:0], "done_kind",
            {28'h0, tagWe, ifillDone, dfillDone, dwriteDone}, {28'h0, e.data[3:0]});
        if (e.data[3]) begin
          chk(tagAddr == e.addr, "tag_addr", {16'h0, tagAddr}, {16'h0, e.addr});
          chk(fillSel == e.sel, "done_sel", 32'(fillSel), 32'(e.sel));
        end
        chk(cyc == e.cyc, "done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bFillWe) begin
      bFills++;
      chk(bFillData[3:1] == bFillWord && !bFillSel, "b_fill", {16'h0, bFillData}, 32'(bFillWord));
    end
    if (bTagWe || bIfillDone || bDfillDone || bDwriteDone) begin
      if (expB.size() == 0)
        chk(1'b0, "b_unexpected_done", {28'h0, bTagWe, bIfillDone, bDfillDone, bDwriteDone}, 32'h0);
      else begin
        e = expB.pop_front();
        chk({bTagWe, bIfillDone, bDfillDone, bDwriteDone} == e.data[3:0], "b_done_kind",
            {28'h0, bTagWe, bIfillDone, bDfillDone, bDwriteDone}, {28'h0, e.data[3:0]});
        chk(bTagAddr == e.addr, "b_tag_addr", {16'h0, bTagAddr}, {16'h0, e.addr});
        chk(cyc == e.cyc, "b_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int c, t, e0;
    rst = 1'b1; imiss = 1'b0; dmiss = 1'b0; dwrite = 1'b0;
    imissAddr = 16'h0; dmissAddr = 16'h0; dwriteAddr = 16'h0; dwriteData = 16'h0;
    bImiss = 1'b0; bImissAddr = 16'h0;
    repeat (3) @(negedge clk);
    chk(busy == 1'b1, "rst_busy", 32'(busy), 32'h1);
    chk(memEn == 1'b0, "rst_mem_en", 32'(memEn), 32'h0);
    chk(memWr == 1'b0, "rst_mem_wr", 32'(memWr), 32'h0);
    chk(memAddr == 16'h0, "rst_mem_addr", {16'h0, memAddr}, 32'h0);
    chk(fillWe == 1'b0, "rst_fill_we", 32'(fillWe), 32'h0);
    chk(fillSel == 1'b0, "rst_fill_sel", 32'(fillSel), 32'h0);
    chk(tagWe == 1'b0, "rst_tag_we", 32'(tagWe), 32'h0);
    chk({ifillDone, dfillDone, dwriteDone} == 3'b000, "rst_done", {29'h0, ifillDone, dfillDone, dwriteDone}, 32'h0);
    chk(bBusy == 1'b1, "rst_b_busy", 32'(bBusy), 32'h1);

    // I miss held from reset release: granted after the flush window.
    e0 = cyc;
    imiss = 1'b1; imissAddr = 16'h0126;
    rst = 1'b0;
    pushFill(1'b0, 16'h0126, e0 + L + 1, W);
    serve(60);
    repeat (2) @(negedge clk);

    // Single write-through store.
    c = cyc;
    dwrite = 1'b1; dwriteAddr = 16'h0040; dwriteData = 16'hBEEF;
    expWr.push_back('{sel: 1'b0, word: 0, addr: 16'h0040, data: 16'hBEEF, cyc: c + 1});
    expEvt.push_back('{sel: 1'b0, word: 0, addr: 16'h0, data: 16'h0001, cyc: c + 1});
    serve(10);
    repeat (2) @(negedge clk);

    // Store, D miss and I miss together: WRITE, then D fill, then I fill.
    c = cyc; t = c + 1;
    dwrite = 1'b1; dwriteAddr = 16'h0200; dwriteData = 16'h1234;
    dmiss = 1'b1; dmissAddr = 16'h031A;
    imiss = 1'b1; imissAddr = 16'h045E;
    expWr.push_back('{sel: 1'b0, word: 0, addr: 16'h0200, data: 16'h1234, cyc: t});
    expEvt.push_back('{sel: 1'b0, word: 0, addr: 16'h0, data: 16'h0001, cyc: t});
    pushFill(1'b1, 16'h031A, t + 2, W);
    pushFill(1'b0, 16'h045E, t + 2 + W + L + 2, W);
    serve(100);
    repeat (2) @(negedge clk);

    // Reset with three fill reads outstanding; D miss stays held.
    c = cyc; t = c + 1;
    dmiss = 1'b1; dmissAddr = 16'h0A08;
    pushFill(1'b1, 16'h0A08, t, 3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    e0 = cyc;
    chk(busy == 1'b1, "abort_busy", 32'(busy), 32'h1);
    chk(memEn == 1'b0, "abort_mem_en", 32'(memEn), 32'h0);
    rst = 1'b0;
    pushFill(1'b1, 16'h0A08, e0 + L + 1, W);
    serve(60);
    repeat (2) @(negedge clk);

    // Stray mem_valid while idle.
    spur = 1'b1; spurData = 16'h5555;
    #1;
    chk(fillWe == 1'b0, "spur_fill_we", 32'(fillWe), 32'h0);
    @(negedge clk);
    spur = 1'b0;
    chk(busy == 1'b0, "spur_busy", 32'(busy), 32'h0);
    chk(memEn == 1'b0, "spur_mem_en", 32'(memEn), 32'h0);

    // Latency-1 instance: back-to-back I misses, one IDLE cycle between them.
    c = cyc; t = c + 1;
    bImiss = 1'b1; bImissAddr = 16'h0100;
    expB.push_back('{sel: 1'b0, word: 0, addr: 16'h0100, data: 16'h000C, cyc: t + W + 1});
    while (cyc < t + W + 1) @(negedge clk);
    bImissAddr = 16'h0180;
    expB.push_back('{sel: 1'b0, word: 0, addr: 16'h0180, data: 16'h000C, cyc: t + 2 * W + 4});
    @(negedge clk);
    chk(bBusy == 1'b0, "b_idle_gap", 32'(bBusy), 32'h0);
    @(negedge clk);
    chk(bBusy == 1'b1, "b_regrant", 32'(bBusy), 32'h1);
    while (cyc < t + 2 * W + 4) @(negedge clk);
    bImiss = 1'b0;

    repeat (10) @(negedge clk);
    chk(expRd.size() == 0, "reads_left", 32'(expRd.size()), 32'h0);
    chk(expWr.size() == 0, "writes_left", 32'(expWr.size()), 32'h0);
    chk(expFill.size() == 0, "fills_left", 32'(expFill.size()), 32'h0);
    chk(expEvt.size() == 0, "dones_left", 32'(expEvt.size()), 32'h0);
    chk(expB.size() == 0, "b_dones_left", 32'(expB.size()), 32'h0);
    chk(bFills == 2 * W, "b_fill_count", 32'(bFills), 32'(2 * W));
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss and write-through controller between the pipelined CPU's I-cache/D-cache and single-ported, pipelined main memory. Arbitrates I-cache misses, D-cache misses and D-cache write-through stores. Streams 8-word block refills into the cache data arrays and finishes each refill with a tag/valid write. Its fill and done strobes set when the pipeline's `icache_hit` / `dcache_hit` / `*_req` trace signals resolve.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, 8: words per cache block; power of two.
- `MEM_LATENCY`, 4: cycles from read issue to `mem_valid`; 1 or more.
- `ADDR_W`, 16: byte-address width.
- `DATA_W`, 16: word width; a word is 2 bytes.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imiss`  in  1  I-cache miss; level, held until `ifill_done`.
- `imiss_addr`  in  ADDR_W  I-side missing byte address.
- `dmiss`  in  1  D-cache miss; level, held until `dfill_done`.
- `dmiss_addr`  in  ADDR_W  D-side missing byte address.
- `dwrite`  in  1  write-through store; level, held until `dwrite_done`.
- `dwrite_addr`  in  ADDR_W  store byte address.
- `dwrite_data`  in  DATA_W  store data.
- `mem_en`  out  1  memory request this cycle.
- `mem_wr`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data.
- `mem_valid`  in  1  `mem_rdata` valid.
- `fill_we`  out  1  write one word into the selected cache data array.
- `fill_sel`  out  1  0 = I-cache, 1 = D-cache.
- `fill_word`  out  log2(WORDS_PER_BLOCK)  word index within the block.
- `fill_data`  out  DATA_W  word to write.
- `tag_we`  out  1  write tag and set valid for `tag_addr` in the `fill_sel` cache.
- `tag_addr`  out  ADDR_W  block-aligned address being filled.
- `ifill_done`, `dfill_done`, `dwrite_done`  out  1 each  one-cycle completion pulses.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - FLUSH: entered on reset. Stays MEM_LATENCY cycles, then goes to IDLE. `mem_valid` is ignored in this state.
  - IDLE: samples requests. Priority is `dwrite` > `dmiss` > `imiss`. Requests not granted stay pending.
  - WRITE: lasts 1 cycle. Drives `mem_en`=1, `mem_wr`=1, `mem_addr`=`dwrite_addr`, `mem_wdata`=`dwrite_data`. Pulses `dwrite_done`, then returns to IDLE.
  - FILL:
    - Latches the block base as `addr & ~(2*WORDS_PER_BLOCK-1)` and latches `fill_sel`.
    - Issues one read per cycle (`mem_en`=1, `mem_wr`=0) until WORDS_PER_BLOCK reads are issued. Issue counter `icnt`.
    - Counts returns with `rcnt`. Each `mem_valid` drives `fill_we`=1, `fill_data`=`mem_rdata`, `fill_word` = the word index of the matching issue, in issue order.
    - Goes to DONE when `rcnt` reaches WORDS_PER_BLOCK.
  - DONE: lasts 1 cycle. Drives `tag_we`=1 and `tag_addr`=block base, and pulses `ifill_done` or `dfill_done` according to `fill_sel`. Returns to IDLE.
- `mem_addr` for a fill read = base + 2*word index.
- Counters are log2(WORDS_PER_BLOCK)+1 bits wide. The word index wraps modulo WORDS_PER_BLOCK.
- `fill_we`, `fill_word` and `fill_data` are combinational from `mem_valid`, `mem_rdata` and `rcnt`. All other outputs are registered.
- `mem_valid` outside FILL is ignored. So is `mem_valid` in FILL once `rcnt` = `icnt`.
- Requesters deassert on the clock edge that samples their done pulse, so IDLE never re-grants a completed request.

## Timing
- Reset values:
  - All outputs 0, except `busy`=1 because the block is in FLUSH.
  - Counters 0, `fill_sel`=0, state FLUSH.
- Reset asserted in any state aborts the operation immediately. No done pulse is produced. After reset, no request is granted for MEM_LATENCY+1 cycles. This discards in-flight reads.
- Store: request sampled in IDLE at edge t. WRITE and `dwrite_done` occur in cycle t+1. Back in IDLE at t+2.
- Fill: request sampled at edge t.
  - Reads are issued in cycles t+1 .. t+WORDS_PER_BLOCK.
  - Returns arrive in cycles t+1+MEM_LATENCY .. t+WORDS_PER_BLOCK+MEM_LATENCY.
  - DONE occurs in cycle t+WORDS_PER_BLOCK+MEM_LATENCY+1. With defaults this is t+13.
- `imiss` and `dmiss` asserted together: the D fill completes first. The I fill is granted on the first IDLE cycle after `dfill_done`.

## Configuration
- `CACHE_FILL_CWF_EN` (critical word first):
  - Defined: fill issue starts at the missed word, `(addr>>1) mod WORDS_PER_BLOCK`, and wraps, e.g. 5,6,7,0,...,4. That word's `fill_we` occurs at t+1+MEM_LATENCY.
  - Undefined: issue always starts at word 0.
  - All other timing is identical in both builds.

## Test plan
- After reset, `imiss` at 0x0126 with memory returning data = address. Required:
  - Reads 0x0120..0x012E.
  - `fill_word` 0..7 with data 0x0120..0x012E, `fill_sel`=0.
  - `tag_we` with `tag_addr`=0x0120 and `ifill_done` exactly 13 cycles after sampling.
  - With `CACHE_FILL_CWF_EN`, the first word is index 3.
- `dwrite`, `dmiss` and `imiss` asserted in the same cycle. Required:
  - WRITE, then the D fill, then the I fill.
  - Exactly one done pulse each, in that order.
- `dwrite` at 0x0040 with data 0xBEEF. Required: one cycle with `mem_en`=1, `mem_wr`=1, `mem_addr`=0x0040, `mem_wdata`=0xBEEF, `dwrite_done`=1.
- Reset asserted while 3 fill reads are in flight, then `dmiss` held. Required:
  - No `dfill_done` and no `tag_we` for the aborted fill.
  - Late `mem_valid` pulses produce no `fill_we`.
  - The new fill is not issued until MEM_LATENCY+1 cycles after reset.
- Spurious `mem_valid` in IDLE. Required: `fill_we`=0 and state unchanged.
- `MEM_LATENCY`=1 build, back-to-back I misses. Required: each `ifill_done` 10 cycles after sampling and one IDLE cycle between fills.
